// File: rtl/spi_flash_prefetch.sv
// -----------------------------------------------------------------------------
// spi_flash_prefetch
//
// Prefetch stage in front of a quad-SPI shift engine. A multi-word flash read
// is split into bursts of at most MAX_BURST words. A burst is only started
// once the output FIFO has room for all of it, because the shift engine cannot
// be stalled once running. Returned words are buffered in the FIFO and handed
// to the consumer over a valid/ready stream, with the final word of each
// request tagged.
//
// Ports:
//   clock, reset        : single clock; synchronous reset, active-low (0 = reset)
//   reqValid/reqReady   : request handshake (ready only while idle)
//   reqAddress[23:0]    : flash byte address, forced to word alignment
//   reqWords[15:0]      : words to read, 0 is a no-op
//   abort               : cancel the current request
//   shiftStart          : one-cycle burst start pulse
//   shiftAddress[23:0]  : burst start address
//   shiftNrOfWords[7:0] : burst length minus one
//   shiftBusy           : shift engine is active
//   shiftDataValid/Data : one returned word from the shift engine
//   outValid/outReady   : output stream handshake
//   outData[31:0]       : FIFO head word
//   outLast             : FIFO head is the last word of its request
//   dropError           : sticky, an unexpected word arrived
// -----------------------------------------------------------------------------
module spi_flash_prefetch #(
    parameter int FIFO_LOG2 = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [23:0] reqAddress,
    input  logic [15:0] reqWords,
    input  logic        abort,
    output logic        shiftStart,
    output logic [23:0] shiftAddress,
    output logic [7:0]  shiftNrOfWords,
    input  logic        shiftBusy,
    input  logic        shiftDataValid,
    input  logic [31:0] shiftData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outData,
    output logic        outLast,
    output logic        dropError
);

    localparam int DEPTH = 1 << FIFO_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAN,
        S_ISSUE,
        S_COLLECT,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [23:0]            r_addr;
    logic [15:0]            r_remaining;
    logic [7:0]             r_in_flight;
    logic [32:0]            r_mem [DEPTH];
    logic [FIFO_LOG2-1:0]   r_wr_ptr;
    logic [FIFO_LOG2-1:0]   r_rd_ptr;
    logic [FIFO_LOG2:0]     r_count;
    logic                   r_drop_error;

    logic [15:0]            w_burst;
    logic [15:0]            w_free;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_word_ok;
    logic                   w_drop;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last;
    logic [7:0]             w_in_flight_nxt;

    // Burst size and free FIFO space are evaluated in 16 bits so that the
    // comparison against the full remaining count needs no truncation.
    assign w_burst = (r_remaining < 16'(MAX_BURST)) ? r_remaining : 16'(MAX_BURST);
    assign w_free  = 16'(DEPTH) - 16'(r_count);

    assign w_accept  = reqValid && (r_state == S_IDLE);
    assign w_abort   = abort && (r_state != S_IDLE);

    // A returned word is only legitimate while a burst is outstanding.
    assign w_word_ok = shiftDataValid && (r_in_flight != 8'd0) &&
                       ((r_state == S_COLLECT) || (r_state == S_FLUSH));
    assign w_drop    = shiftDataValid && !w_word_ok;

    // Words that coincide with an abort are discarded but still counted.
    assign w_push    = w_word_ok && (r_state == S_COLLECT) && !w_abort;
    assign w_pop     = outValid && outReady && !w_abort;
    assign w_last    = (r_in_flight == 8'd1) && (r_remaining == 16'd0);

    always_comb begin
        w_in_flight_nxt = r_in_flight;
        if (r_state == S_ISSUE) begin
            w_in_flight_nxt = w_burst[7:0];
        end else if (w_word_ok) begin
            w_in_flight_nxt = r_in_flight - 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path
    // through the case statement can leave a value held and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (reqWords != 16'd0)) begin
                    w_state_nxt = S_PLAN;
                end
            end
            S_PLAN: begin
                if (!shiftBusy && (w_free >= w_burst)) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_word_ok && (r_in_flight == 8'd1)) begin
                    w_state_nxt = (r_remaining != 16'd0) ? S_PLAN : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (w_in_flight_nxt == 8'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // An abort issued during ISSUE still has a full burst coming back,
        // which w_in_flight_nxt already reflects.
        if (w_abort) begin
            w_state_nxt = (w_in_flight_nxt != 8'd0) ? S_FLUSH : S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Request bookkeeping and FIFO control
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr       <= '0;
            r_remaining  <= '0;
            r_in_flight  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_error <= 1'b0;
        end else begin
            r_in_flight <= w_in_flight_nxt;

            if (w_drop) begin
                r_drop_error <= 1'b1;
            end

            if (w_accept) begin
                r_addr      <= {reqAddress[23:2], 2'b00};
                r_remaining <= reqWords;
            end else if (r_state == S_ISSUE) begin
                // 24-bit addition wraps at the top of the flash address space.
                r_addr      <= r_addr + (24'(w_burst) << 2);
                r_remaining <= r_remaining - w_burst;
            end

            if (w_abort) begin
                r_remaining <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: the FIFO storage has no reset; stale contents are never visible
    // because outValid and outLast are qualified by the (reset) count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, shiftData};
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign reqReady       = (r_state == S_IDLE);
    assign shiftStart     = (r_state == S_ISSUE);
    assign shiftAddress   = (r_state == S_ISSUE) ? r_addr : 24'd0;
    assign shiftNrOfWords = (r_state == S_ISSUE) ? 8'(w_burst - 16'd1) : 8'd0;

    assign outValid       = (r_count != '0);
    assign outData        = r_mem[r_rd_ptr][31:0];
    assign outLast        = outValid && r_mem[r_rd_ptr][32];
    assign dropError      = r_drop_error;

endmodule

// File: tb/tb_spi_flash_prefetch.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_prefetch
//
// Self-checking bench for spi_flash_prefetch. A behavioural shift engine
// answers each shiftStart with the requested number of words; every word it
// returns that the consumer should see is pushed to a scoreboard queue and
// compared when the DUT presents it. Expected bursts are computed from each
// request and compared against every shiftStart pulse.
// -----------------------------------------------------------------------------
module tb_spi_flash_prefetch;

    localparam int FIFO_LOG2 = 4;
    localparam int MB        = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [23:0] reqAddress = '0;
    logic [15:0] reqWords = '0;
    logic        abort = 1'b0;
    logic        shiftStart;
    logic [23:0] shiftAddress;
    logic [7:0]  shiftNrOfWords;
    logic        shiftBusy = 1'b0;
    logic        shiftDataValid = 1'b0;
    logic [31:0] shiftData = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] outData;
    logic        outLast;
    logic        dropError;

    spi_flash_prefetch #(
        .FIFO_LOG2 (FIFO_LOG2),
        .MAX_BURST (MB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqAddress     (reqAddress),
        .reqWords       (reqWords),
        .abort          (abort),
        .shiftStart     (shiftStart),
        .shiftAddress   (shiftAddress),
        .shiftNrOfWords (shiftNrOfWords),
        .shiftBusy      (shiftBusy),
        .shiftDataValid (shiftDataValid),
        .shiftData      (shiftData),
        .outValid       (outValid),
        .outReady       (outReady),
        .outData        (outData),
        .outLast        (outLast),
        .dropError      (dropError)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_miss = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          start_cyc = 0;
    int          n_starts = 0;

    logic [32:0] sb_q[$];      // {last, data} expected at the output
    logic [31:0] burst_q[$];   // {address, nr_of_words} expected per burst

    // Shift engine model state
    logic [23:0] se_addr = '0;
    int          se_left = 0;
    int          se_wait = 0;
    int          se_gap = 0;
    int          se_sent = 0;
    bit          se_load = 1'b0;
    logic [23:0] se_load_addr = '0;
    logic [7:0]  se_load_nr = '0;
    int          req_left = 0;
    bit          sb_discard = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: score what the DUT presents now, let the edge happen,
    // then drive the shift engine's response for the next cycle.
    task automatic step();
        logic [32:0] e;
        logic [31:0] b;
        if (outValid && outReady) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 64'(outValid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(outData), 64'(e[31:0]));
                check("out_last", 64'(outLast), 64'(e[32]));
            end
        end
        se_load = 1'b0;
        if (shiftStart) begin
            n_starts++;
            start_cyc = cyc;
            if (burst_q.size() == 0) begin
                check("spurious_start", 64'(shiftStart), 64'd0);
            end else begin
                b = burst_q.pop_front();
                check("shift_addr", 64'(shiftAddress), 64'(b[31:8]));
                check("shift_nr", 64'(shiftNrOfWords), 64'(b[7:0]));
            end
            se_load      = 1'b1;
            se_load_addr = shiftAddress;
            se_load_nr   = shiftNrOfWords;
        end

        @(posedge clock);
        #1;
        cyc++;

        shiftDataValid = 1'b0;
        if (se_load) begin
            se_addr = se_load_addr;
            se_left = int'(se_load_nr) + 1;
            se_wait = 1;
            se_sent = 0;
        end else if (se_left > 0) begin
            if (se_wait > 0) begin
                se_wait--;
            end else begin
                shiftDataValid = 1'b1;
                shiftData      = {8'hA5, se_addr} ^ 32'(se_sent << 28);
                if (!sb_discard) begin
                    sb_q.push_back({(req_left == 1), shiftData});
                end
                req_left--;
                se_addr = se_addr + 24'd4;
                se_left--;
                se_sent++;
                se_wait = se_gap;
            end
        end
        shiftBusy = se_load || (se_left > 0) || shiftDataValid;
    endtask

    task automatic do_request(input logic [23:0] addr, input logic [15:0] words);
        logic [23:0] a;
        int          rem;
        int          b;
        a   = {addr[23:2], 2'b00};
        rem = int'(words);
        while (rem > 0) begin
            b = (rem < MB) ? rem : MB;
            burst_q.push_back({a, 8'(b - 1)});
            a   = a + 24'(4 * b);
            rem = rem - b;
        end
        req_left   = int'(words);
        sb_discard = 1'b0;
        check("req_ready_idle", 64'(reqReady), 64'd1);
        reqValid   = 1'b1;
        reqAddress = addr;
        reqWords   = words;
        step();
        reqValid   = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || burst_q.size() != 0 || se_left > 0 || !reqReady) &&
               n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        int n0;
        int n;

        // ---------------- reset values ----------------
        reset = 1'b0;
        step();
        step();
        check("rst_req_ready", 64'(reqReady), 64'd1);
        check("rst_shift_start", 64'(shiftStart), 64'd0);
        check("rst_shift_addr", 64'(shiftAddress), 64'd0);
        check("rst_shift_nr", 64'(shiftNrOfWords), 64'd0);
        check("rst_out_valid", 64'(outValid), 64'd0);
        check("rst_out_last", 64'(outLast), 64'd0);
        check("rst_drop_error", 64'(dropError), 64'd0);
        reset = 1'b1;
        step();

        // ---------------- short unaligned request ----------------
        outReady = 1'b1;
        n0 = n_starts;
        do_request(24'h000103, 16'd3);
        wait_idle("t1_done", 100);
        check("t1_issue_latency", 64'(start_cyc - accept_cyc), 64'd1);
        check("t1_nr_bursts", 64'(n_starts - n0), 64'd1);

        // ---------------- 20 words, consumer stalled ----------------
        outReady = 1'b0;
        n0 = n_starts;
        do_request(24'h000200, 16'd20);
        repeat (60) step();
        check("t2_third_held", 64'(n_starts - n0), 64'd2);
        check("t2_fifo_holding", 64'(outValid), 64'd1);
        check("t2_busy", 64'(reqReady), 64'd0);
        outReady = 1'b1;
        wait_idle("t2_done", 300);
        check("t2_nr_bursts", 64'(n_starts - n0), 64'd3);

        // ---------------- address wrap across bursts ----------------
        n0 = n_starts;
        do_request(24'hFFFFF1, 16'd12);
        wait_idle("t3_done", 200);
        check("t3_nr_bursts", 64'(n_starts - n0), 64'd2);
        check("t3_no_drop", 64'(dropError), 64'd0);

        // ---------------- abort mid-burst ----------------
        outReady = 1'b0;
        se_gap   = 1;
        do_request(24'h001000, 16'd8);
        n = 0;
        while (!(se_sent == 3 && shiftDataValid) && n < 60) begin
            step();
            n++;
        end
        check("t4_third_word_seen", 64'(n < 60), 64'd1);
        step();                      // third word enters the FIFO
        check("t4_fifo_before_abort", 64'(outValid), 64'd1);
        abort      = 1'b1;
        sb_discard = 1'b1;
        sb_q.delete();
        step();
        abort = 1'b0;
        check("t4_fifo_emptied", 64'(outValid), 64'd0);
        check("t4_flushing", 64'(reqReady), 64'd0);
        n = 0;
        while (!(se_sent == 8 && shiftDataValid) && n < 60) begin
            step();
            n++;
        end
        check("t4_last_word_seen", 64'(n < 60), 64'd1);
        check("t4_busy_before_last", 64'(reqReady), 64'd0);
        step();
        check("t4_idle_after_last", 64'(reqReady), 64'd1);
        check("t4_no_drop", 64'(dropError), 64'd0);
        check("t4_no_output", 64'(outValid), 64'd0);
        se_gap     = 0;
        sb_discard = 1'b0;
        outReady   = 1'b1;
        step();

        // ---------------- unexpected word in IDLE ----------------
        shiftDataValid = 1'b1;
        shiftData      = 32'h1234_5678;
        step();
        check("t5_drop_set", 64'(dropError), 64'd1);
        check("t5_no_output", 64'(outValid), 64'd0);
        repeat (3) step();
        check("t5_drop_sticky", 64'(dropError), 64'd1);
        check("t5_still_no_output", 64'(outValid), 64'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t5_drop_cleared", 64'(dropError), 64'd0);
        check("t5_idle", 64'(reqReady), 64'd1);
        step();

        // ---------------- zero-length request ----------------
        n0 = n_starts;
        do_request(24'h000400, 16'd0);
        check("t6_ready", 64'(reqReady), 64'd1);
        repeat (5) step();
        check("t6_no_start", 64'(n_starts - n0), 64'd0);
        check("t6_no_output", 64'(outValid), 64'd0);
        check("t6_still_ready", 64'(reqReady), 64'd1);

        // ---------------- reset in the middle of a burst ----------------
        do_request(24'h000800, 16'd8);
        n = 0;
        while (!(se_sent == 2 && shiftDataValid) && n < 60) begin
            step();
            n++;
        end
        check("t7_words_started", 64'(n < 60), 64'd1);
        sb_discard = 1'b1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        sb_q.delete();
        burst_q.delete();
        check("t7_idle_after_reset", 64'(reqReady), 64'd1);
        check("t7_fifo_cleared", 64'(outValid), 64'd0);
        n = 0;
        while (se_left > 0 && n < 60) begin
            step();
            n++;
        end
        step();
        check("t7_late_words_dropped", 64'(dropError), 64'd1);
        check("t7_no_output", 64'(outValid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
